maxpool2d_mem: RTL and testbench

Memory-to-memory 2-D max-pooling stage that sits directly downstream of the convolution stage. It reads the NCHW feature map the convolution writes to output memory, reduces each POOL_SIZE×POOL_SIZE window to its signed maximum, and writes the pooled NCHW map to a second memory. It is sequenced by the same start/done/valid handshake and uses the same single-port enable-style memory interfaces as the convolution stage.

---
 rtl/pool_pkg.sv | 24 ++
 rtl/maxpool2d_mem_if.sv | 27 ++
 rtl/pool_window_ctr.sv | 87 ++++++++
 rtl/maxpool2d_mem.sv | 144 ++++++++++++++
 tb/tb_maxpool2d_mem.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling stage (also usable by the convolution stage).
// Holds the state encoding, the most-negative constant and the output-dimension arithmetic.
package pool_pkg;

  localparam int IDX_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } pool_state_e;

  function automatic logic [63:0] most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

  function automatic int out_dim(input int in_dim, input int pool, input int stride, input int pad);
    return (in_dim + 2 * pad - pool) / stride + 1;
  endfunction

endpackage

// File: rtl/maxpool2d_mem_if.sv
// Handshake plus read/write memory ports of the max-pooling stage.
// master = pooling engine, slave = sequencer and memories.
interface maxpool2d_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                         start;
  logic                         done;
  logic                         valid;
  logic        [ADDR_WIDTH-1:0] input_addr;
  logic signed [DATA_WIDTH-1:0] input_data;
  logic                         input_en;
  logic        [ADDR_WIDTH-1:0] output_addr;
  logic signed [DATA_WIDTH-1:0] output_data;
  logic                         output_we;
  logic                         output_en;

  modport master (
    input  start, input_data,
    output done, valid, input_addr, input_en, output_addr, output_data, output_we, output_en
  );

  modport slave (
    output start, input_data,
    input  done, valid, input_addr, input_en, output_addr, output_data, output_we, output_en
  );
endinterface

// File: rtl/pool_window_ctr.sv
// Nested loop counters for max-pooling: batch, channel, out row, out col, window row, window col.
// Window indices advance per CAPTURE, output indices per WRITE; flags mark window end and run end.
module pool_window_ctr
  import pool_pkg::*;
#(
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 1,
  parameter int OUT_H      = 2,
  parameter int OUT_W      = 2,
  parameter int POOL_SIZE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic             clr_win,
  input  logic             adv_win,
  input  logic             adv_out,
  output logic [IDX_W-1:0] b,
  output logic [IDX_W-1:0] c,
  output logic [IDX_W-1:0] orow,
  output logic [IDX_W-1:0] ocol,
  output logic [IDX_W-1:0] wr,
  output logic [IDX_W-1:0] wc,
  output logic             win_last,
  output logic             run_last
);

  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(BATCH_SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] LAST_H = IDX_W'(OUT_H - 1);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(POOL_SIZE - 1);

  assign win_last = (wr == LAST_P) && (wc == LAST_P);
  assign run_last = (b == LAST_B) && (c == LAST_C) && (orow == LAST_H) && (ocol == LAST_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b    <= '0;
      c    <= '0;
      orow <= '0;
      ocol <= '0;
      wr   <= '0;
      wc   <= '0;
    end else if (clr_all) begin
      b    <= '0;
      c    <= '0;
      orow <= '0;
      ocol <= '0;
      wr   <= '0;
      wc   <= '0;
    end else begin
      if (clr_win) begin
        wr <= '0;
        wc <= '0;
      end else if (adv_win) begin
        if (wc == LAST_P) begin
          wc <= '0;
          wr <= (wr == LAST_P) ? '0 : wr + ONE;
        end else begin
          wc <= wc + ONE;
        end
      end
      // Output carry chain: ocol -> orow -> channel -> batch.
      if (adv_out) begin
        if (ocol == LAST_W) begin
          ocol <= '0;
          if (orow == LAST_H) begin
            orow <= '0;
            if (c == LAST_C) begin
              c <= '0;
              b <= (b == LAST_B) ? '0 : b + ONE;
            end else begin
              c <= c + ONE;
            end
          end else begin
            orow <= orow + ONE;
          end
        end else begin
          ocol <= ocol + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/maxpool2d_mem.sv
// Memory-to-memory NCHW 2-D max-pool: one read per in-bounds window element, one write per output.
// Build option POOL_RELU_EN: running max starts at 0, fusing a ReLU into the pooling.
module maxpool2d_mem
  import pool_pkg::*;
#(
  parameter int BATCH_SIZE = 1,
  parameter int CHANNELS   = 1,
  parameter int IN_HEIGHT  = 4,
  parameter int IN_WIDTH   = 4,
  parameter int POOL_SIZE  = 2,
  parameter int STRIDE     = 2,
  parameter int PADDING    = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  maxpool2d_mem_if.master bus
);

  localparam int OUT_H = out_dim(IN_HEIGHT, POOL_SIZE, STRIDE, PADDING);
  localparam int OUT_W = out_dim(IN_WIDTH, POOL_SIZE, STRIDE, PADDING);
  localparam int PLANE = IN_HEIGHT * IN_WIDTH;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_INIT    = INIT;
  localparam logic [2:0] S_ISSUE   = ISSUE;
  localparam logic [2:0] S_CAPTURE = CAPTURE;
  localparam logic [2:0] S_WRITE   = WRITE;
  localparam logic [2:0] S_DONE    = DONE;

`ifdef POOL_RELU_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = '0;
`else
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = DATA_WIDTH'(most_neg(DATA_WIDTH));
`endif

  function automatic logic signed [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                        input logic signed [DATA_WIDTH-1:0] b);
    return (b > a) ? b : a;
  endfunction

  logic [2:0]                   state_q;
  logic [2:0]                   state_d;
  logic                         pending_q;
  logic                         any_valid_q;
  logic        [ADDR_WIDTH-1:0] out_addr_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic signed [DATA_WIDTH-1:0] result;

  logic [IDX_W-1:0] b, c, orow, ocol, wr, wc;
  logic             win_last, run_last;
  logic             clr_all, clr_win, adv_win, adv_out;

  logic signed [31:0] in_r, in_c, plane, rd_addr;
  logic               in_bounds;
  logic               rd_en, wr_en;

  assign clr_all = (state_q == S_IDLE) && bus.start;
  assign clr_win = (state_q == S_INIT);
  assign adv_win = (state_q == S_CAPTURE);
  assign adv_out = (state_q == S_WRITE);

  pool_window_ctr #(
    .BATCH_SIZE(BATCH_SIZE),
    .CHANNELS  (CHANNELS),
    .OUT_H     (OUT_H),
    .OUT_W     (OUT_W),
    .POOL_SIZE (POOL_SIZE)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_all (clr_all),
    .clr_win (clr_win),
    .adv_win (adv_win),
    .adv_out (adv_out),
    .b       (b),
    .c       (c),
    .orow    (orow),
    .ocol    (ocol),
    .wr      (wr),
    .wc      (wc),
    .win_last(win_last),
    .run_last(run_last)
  );

  // Window element coordinates may fall into the padding border (negative or past the edge).
  always_comb begin
    in_r      = signed'(32'(orow)) * STRIDE + signed'(32'(wr)) - PADDING;
    in_c      = signed'(32'(ocol)) * STRIDE + signed'(32'(wc)) - PADDING;
    plane     = signed'(32'(b)) * CHANNELS + signed'(32'(c));
    rd_addr   = plane * PLANE + in_r * IN_WIDTH + in_c;
    in_bounds = (in_r >= 0) && (in_r < IN_HEIGHT) && (in_c >= 0) && (in_c < IN_WIDTH);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_INIT;
      S_INIT:    state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = win_last ? S_WRITE : S_ISSUE;
      S_WRITE:   state_d = run_last ? S_DONE : S_INIT;
      S_DONE:    if (!bus.start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      any_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clr_all) out_addr_q <= '0;
      else if (adv_out) out_addr_q <= out_addr_q + ADDR_WIDTH'(1);
      if (state_q == S_ISSUE) pending_q <= in_bounds;
      if (clr_win) any_valid_q <= 1'b0;
      else if (adv_win && pending_q) any_valid_q <= 1'b1;
    end
  end

  // Running max: read data lands the cycle after the ISSUE strobe.
  always_ff @(posedge clk) begin
    if (clr_win) max_q <= MAX_INIT;
    else if (adv_win && pending_q) max_q <= smax(max_q, bus.input_data);
  end

  assign result = any_valid_q ? max_q : '0;
  assign rd_en  = (state_q == S_ISSUE) && in_bounds;
  assign wr_en  = (state_q == S_WRITE);

  assign bus.input_en    = rd_en;
  assign bus.input_addr  = rd_en ? ADDR_WIDTH'(rd_addr) : '0;
  assign bus.output_we   = wr_en;
  assign bus.output_en   = wr_en;
  assign bus.output_addr = wr_en ? out_addr_q : '0;
  assign bus.output_data = wr_en ? result : '0;
  assign bus.done        = (state_q == S_DONE);
  assign bus.valid       = (state_q == S_DONE);

endmodule

// File: tb/tb_maxpool2d_mem.sv
// Directed bench for maxpool2d_mem: three instances (base 4x4, padded, multi batch/channel).
// Expected outputs are hand-computed tables; POOL_RELU_EN selects the clamped expectations.
module tb_maxpool2d_mem;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  maxpool2d_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ia ();
  maxpool2d_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ip ();
  maxpool2d_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) im ();

  maxpool2d_mem dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  maxpool2d_mem #(.PADDING(1)) dut_p (.clk(clk), .rst(rst), .bus(ip.master));
  maxpool2d_mem #(.BATCH_SIZE(2), .CHANNELS(2)) dut_m (.clk(clk), .rst(rst), .bus(im.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] mem_a [16];
  logic signed [31:0] mem_p [16];
  logic signed [31:0] mem_m [64];

  always @(posedge clk) begin
    if (ia.input_en) ia.input_data <= mem_a[ia.input_addr[3:0]];
    if (ip.input_en) ip.input_data <= mem_p[ip.input_addr[3:0]];
    if (im.input_en) im.input_data <= mem_m[im.input_addr[5:0]];
  end

  logic        [15:0] wa_a [64];
  logic signed [31:0] wa_d [64];
  logic        [15:0] wp_a [64];
  logic signed [31:0] wp_d [64];
  logic        [15:0] wm_a [64];
  logic signed [31:0] wm_d [64];
  int wn_a = 0, wn_p = 0, wn_m = 0;
  int en_bad = 0, rd_n_p = 0, rd_bad_p = 0;

  always @(negedge clk) begin
    if (ia.output_we) begin
      if (wn_a < 64) begin wa_a[wn_a] <= ia.output_addr; wa_d[wn_a] <= ia.output_data; end
      wn_a <= wn_a + 1;
    end
    if (ip.output_we) begin
      if (wn_p < 64) begin wp_a[wn_p] <= ip.output_addr; wp_d[wn_p] <= ip.output_data; end
      wn_p <= wn_p + 1;
    end
    if (im.output_we) begin
      if (wn_m < 64) begin wm_a[wn_m] <= im.output_addr; wm_d[wn_m] <= im.output_data; end
      wn_m <= wn_m + 1;
    end
    if ((ia.output_en !== ia.output_we) || (ip.output_en !== ip.output_we) ||
        (im.output_en !== im.output_we)) en_bad <= en_bad + 1;
    if (ip.input_en) begin
      rd_n_p <= rd_n_p + 1;
      if (ip.input_addr >= 16'd16) rd_bad_p <= rd_bad_p + 1;
    end
  end

  int exp4 [4] = '{5, 7, 13, 15};
  int exp9 [9] = '{0, 2, 3, 8, 10, 11, 12, 14, 15};

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       ia.start = v;
      1:       ip.start = v;
      default: im.start = v;
    endcase
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      0:       return ia.done;
      1:       return ip.done;
      default: return im.done;
    endcase
  endfunction

  // Starts a run and counts rising edges from the one sampling start to the one raising done.
  task automatic run(input int sel, input bit hold, output int cyc);
    @(negedge clk);
    set_start(sel, 1'b1);
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!hold) set_start(sel, 1'b0);
      if (sel_done(sel)) break;
    end
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ramp_a();
    for (int i = 0; i < 16; i++) mem_a[i] = i;
  endtask

  task automatic check_ramp_a(input int base, input string tag);
    total++;
    if (wn_a - base !== 4) begin
      bad++;
      $display("FAIL %s write count got=%0d want=4", tag, wn_a - base);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wa_a[base + k] !== 16'(k) || wa_d[base + k] !== exp4[k]) begin
        bad++;
        $display("FAIL %s write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                 tag, k, wa_a[base + k], wa_d[base + k], k, exp4[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ia.start = 1'b0;
    ip.start = 1'b0;
    im.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ia.done, ia.valid, ia.input_en, ia.output_we, ia.output_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset strobes got=%b want=00000",
               {ia.done, ia.valid, ia.input_en, ia.output_we, ia.output_en});
    end
    total++;
    if (ia.input_addr !== 16'd0 || ia.output_addr !== 16'd0 || ia.output_data !== 32'sd0) begin
      bad++;
      $display("FAIL reset buses got in_addr=%0d out_addr=%0d out_data=%0d want 0 0 0",
               ia.input_addr, ia.output_addr, ia.output_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ramp();
    int cyc, base;
    load_ramp_a();
    base = wn_a;
    run(0, 1'b0, cyc);
    total++;
    if (cyc !== 41) begin
      bad++;
      $display("FAIL ramp latency got=%0d want=41", cyc);
    end
    check_ramp_a(base, "ramp");
  endtask

  task automatic test_negative();
    int cyc, base, want;
`ifdef POOL_RELU_EN
    want = 0;
`else
    want = -3;
`endif
    for (int i = 0; i < 16; i++) mem_a[i] = -3;
    base = wn_a;
    run(0, 1'b0, cyc);
    total++;
    if (wn_a - base !== 4) begin
      bad++;
      $display("FAIL neg write count got=%0d want=4", wn_a - base);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wa_d[base + k] !== want) begin
        bad++;
        $display("FAIL neg data%0d got=%0d want=%0d", k, wa_d[base + k], want);
      end
    end
  endtask

  task automatic test_padding();
    int cyc, base, rd0;
    for (int i = 0; i < 16; i++) mem_p[i] = i;
    base = wn_p;
    rd0  = rd_n_p;
    run(1, 1'b0, cyc);
    total++;
    if (cyc !== 91) begin
      bad++;
      $display("FAIL pad latency got=%0d want=91", cyc);
    end
    total++;
    if (wn_p - base !== 9) begin
      bad++;
      $display("FAIL pad write count got=%0d want=9", wn_p - base);
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (wp_a[base + k] !== 16'(k) || wp_d[base + k] !== exp9[k]) begin
        bad++;
        $display("FAIL pad write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                 k, wp_a[base + k], wp_d[base + k], k, exp9[k]);
      end
    end
    total++;
    if (rd_n_p - rd0 !== 16 || rd_bad_p !== 0) begin
      bad++;
      $display("FAIL pad reads got count=%0d oob=%0d want count=16 oob=0", rd_n_p - rd0, rd_bad_p);
    end
  endtask

  task automatic test_multi();
    int cyc, base, want;
    for (int i = 0; i < 64; i++) mem_m[i] = (i / 16) * 100 + (i % 16);
    base = wn_m;
    run(2, 1'b0, cyc);
    total++;
    if (cyc !== 161) begin
      bad++;
      $display("FAIL multi latency got=%0d want=161", cyc);
    end
    total++;
    if (wn_m - base !== 16) begin
      bad++;
      $display("FAIL multi write count got=%0d want=16", wn_m - base);
    end
    for (int k = 0; k < 16; k++) begin
      want = (k / 4) * 100 + exp4[k % 4];
      total++;
      if (wm_a[base + k] !== 16'(k) || wm_d[base + k] !== want) begin
        bad++;
        $display("FAIL multi write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                 k, wm_a[base + k], wm_d[base + k], k, want);
      end
    end
  endtask

  task automatic test_hold_start();
    int cyc, base;
    load_ramp_a();
    base = wn_a;
    run(0, 1'b1, cyc);
    total++;
    if (cyc !== 41) begin
      bad++;
      $display("FAIL hold latency got=%0d want=41", cyc);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (ia.done !== 1'b1 || ia.valid !== 1'b1 || wn_a - base !== 4) begin
      bad++;
      $display("FAIL hold dwell got done=%b valid=%b writes=%0d want 1 1 4",
               ia.done, ia.valid, wn_a - base);
    end
    @(negedge clk);
    ia.start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ia.done !== 1'b0 || ia.valid !== 1'b0) begin
      bad++;
      $display("FAIL hold release got done=%b valid=%b want 0 0", ia.done, ia.valid);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wn_a - base !== 4) begin
      bad++;
      $display("FAIL hold single run got writes=%0d want=4", wn_a - base);
    end
    base = wn_a;
    run(0, 1'b0, cyc);
    check_ramp_a(base, "rerun");
  endtask

  task automatic test_reset_mid_run();
    int cyc, base;
    load_ramp_a();
    base = wn_a;
    @(negedge clk);
    ia.start = 1'b1;
    @(posedge clk);
    #1;
    ia.start = 1'b0;
    repeat (22) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({ia.done, ia.valid, ia.input_en, ia.output_we, ia.output_en} !== 5'b0) begin
      bad++;
      $display("FAIL abort strobes got=%b want=00000",
               {ia.done, ia.valid, ia.input_en, ia.output_we, ia.output_en});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wn_a - base !== 2) begin
      bad++;
      $display("FAIL abort partial writes got=%0d want=2", wn_a - base);
    end
    @(negedge clk);
    rst = 1'b1;
    base = wn_a;
    run(0, 1'b0, cyc);
    total++;
    if (cyc !== 41) begin
      bad++;
      $display("FAIL post-abort latency got=%0d want=41", cyc);
    end
    check_ramp_a(base, "post-abort");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_padding();
    test_multi();
    test_hold_start();
    test_reset_mid_run();
    total++;
    if (en_bad !== 0) begin
      bad++;
      $display("FAIL output_en tracking got=%0d cycles differing want=0", en_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
